// File: rtl/branch_predictor_ctrl.sv
// branch_predictor_ctrl
// Table of 2-bit saturating local branch predictors for the pipelined core.
// Fetch reads a PC-indexed prediction combinationally; execute trains the
// entry of the resolving branch. After reset an init sweep loads every entry
// with weakly-untaken before predictions and updates are honoured.
// Optional build macro: BRANCH_PRED_STATS_EN adds saturating branch and
// misprediction counters (branch_cnt_o, mispredict_cnt_o).

module branch_predictor_ctrl #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] pc_f_i,
    input  logic [ADDR_W-1:0] pc_e_i,
    input  logic              branch_op_e_i,
    input  logic              stall_e_i,
    input  logic              pc_src_res_e_i,
    input  logic              pc_src_pred_e_i,
    output logic              pc_src_pred_f_o,
    output logic              mispredict_e_o,
    output logic              init_busy_o
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       mispredict_cnt_o
`endif
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Counter encoding; the prediction is the counter's upper bit
    localparam logic [1:0] CNT_ST = 2'b11;
    localparam logic [1:0] CNT_WT = 2'b10;
    localparam logic [1:0] CNT_WU = 2'b01;
    localparam logic [1:0] CNT_SU = 2'b00;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [1:0]       r_table [DEPTH];

    logic [IDX_W-1:0] w_idx_f;
    logic [IDX_W-1:0] w_idx_e;
    logic             w_run;
    logic             w_upd;
    logic [1:0]       w_cur_e;
    logic [1:0]       w_next_e;
    logic             w_unused_pc;

    // Word-aligned PCs: drop the byte offset and use the next IDX_W bits
    assign w_idx_f = pc_f_i[IDX_W+1:2];
    assign w_idx_e = pc_e_i[IDX_W+1:2];

    // Upper PC bits and byte offset do not take part in indexing
    assign w_unused_pc = ^{pc_f_i[ADDR_W-1:IDX_W+2], pc_f_i[1:0],
                           pc_e_i[ADDR_W-1:IDX_W+2], pc_e_i[1:0], CNT_WT};

    assign w_run   = (r_state == S_RUN);
    assign w_upd   = w_run & branch_op_e_i & ~stall_e_i;
    assign w_cur_e = r_table[w_idx_e];

    // Reading the table before the write lands gives the pre-update value
    // on a same-index fetch/execute collision
    assign pc_src_pred_f_o = w_run & r_table[w_idx_f][1];
    assign mispredict_e_o  = w_upd & (pc_src_pred_e_i != pc_src_res_e_i);
    assign init_busy_o     = ~w_run;

    // Saturating step of the resolving branch's counter, never wrapping
    always_comb begin
        w_next_e = w_cur_e;
        if (pc_src_res_e_i) begin
            if (w_cur_e != CNT_ST) begin
                w_next_e = w_cur_e + 2'd1;
            end
        end else begin
            if (w_cur_e != CNT_SU) begin
                w_next_e = w_cur_e - 2'd1;
            end
        end
    end

    // Sequencer: reset restarts the sweep, last swept entry hands over to RUN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
        end else if (r_state == S_INIT) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == LAST_IDX) begin
                r_state <= S_RUN;
            end
        end
    end

    // Table storage: sweep writes WU, RUN trains the resolving entry
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (r_state == S_INIT) begin
                r_table[r_ptr] <= CNT_WU;
            end else if (w_upd) begin
                r_table[w_idx_e] <= w_next_e;
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    // Saturating statistics; upd is never set during the sweep so both hold
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_upd && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (mispredict_e_o && (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;
`else
    // Statistics build disabled: no counters or extra ports
`endif

endmodule
